// File: rtl/div_ratio_ctrl_pkg.sv
// Shared FSM encoding and prescale/ratio constants for the UART divide-ratio controller.
package div_ratio_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int unsigned PS_32 = 32;
  localparam int unsigned PS_16 = 16;
  localparam int unsigned PS_8  = 8;
  localparam int unsigned PS_4  = 4;

  localparam int unsigned RATIO_1 = 1;
  localparam int unsigned RATIO_2 = 2;
  localparam int unsigned RATIO_4 = 4;
  localparam int unsigned RATIO_8 = 8;

  localparam int unsigned RATIO_DEFAULT = RATIO_1;

endpackage

// File: rtl/div_ratio_ctrl_dec.sv
// Combinational prescale -> power-of-two divide ratio decode; unsupported values fall back to ratio 1.
module prescale_ratio_dec
  import div_ratio_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned RATIO_W    = 8
) (
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [RATIO_W-1:0]    o_ratio,
  output logic                  o_err
);

  logic [31:0] w_ps;

  // Zero-extend so the compare is against the full constant value.
  assign w_ps = 32'(i_prescale);

  always_comb begin
    o_ratio = RATIO_W'(RATIO_DEFAULT);
    o_err   = 1'b0;
    case (w_ps)
      PS_32:   o_ratio = RATIO_W'(RATIO_1);
      PS_16:   o_ratio = RATIO_W'(RATIO_2);
      PS_8:    o_ratio = RATIO_W'(RATIO_4);
      PS_4:    o_ratio = RATIO_W'(RATIO_8);
      default: o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time divide-ratio controller: config handshake, boundary-aligned ratio switch,
// divided tick and divided level for the UART sampling logic.
module div_ratio_ctrl
  import div_ratio_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned RATIO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic                  div_tick,
  output logic                  div_clk,
  output logic [RATIO_W-1:0]    active_ratio,
  output logic                  busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [RATIO_W-1:0]   r_cnt;
  logic [RATIO_W-1:0]   w_cnt_nxt;
  logic [RATIO_W-1:0]   r_active;
  logic [RATIO_W-1:0]   w_active_nxt;
  logic [RATIO_W-1:0]   r_pending;
  logic [RATIO_W-1:0]   w_pending_nxt;
  logic                 r_err;

  logic [RATIO_W-1:0]   w_dec_ratio;
  logic                 w_dec_err;
  logic                 w_accept;
  logic                 w_wrap;
  logic                 w_running;
  logic [RATIO_W-1:0]   w_half;

  prescale_ratio_dec #(
    .PRESCALE_W (PRESCALE_W),
    .RATIO_W    (RATIO_W)
  ) u_dec (
    .i_prescale (cfg_prescale),
    .o_ratio    (w_dec_ratio),
    .o_err      (w_dec_err)
  );

  assign w_running = (r_state != ST_OFF);
  assign w_wrap    = (r_cnt == (r_active - RATIO_W'(1)));
  assign cfg_ready = (r_state != ST_PEND);
  assign w_accept  = cfg_valid & cfg_ready;

  // Ratio 1 has no low phase, so its high-phase length is forced to 1.
  assign w_half = (r_active == RATIO_W'(1)) ? RATIO_W'(1) : (r_active >> 1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    unique case (r_state)
      ST_OFF: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_active_nxt = w_dec_ratio;
        end
        if (en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
          if (w_accept) begin
            w_active_nxt = w_dec_ratio;
          end
        end else begin
          w_cnt_nxt = w_wrap ? '0 : (r_cnt + RATIO_W'(1));
          if (w_accept) begin
            w_pending_nxt = w_dec_ratio;
            w_state_nxt   = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!en) begin
          w_state_nxt  = ST_OFF;
          w_cnt_nxt    = '0;
          w_active_nxt = r_pending;
        end else if (w_wrap) begin
          w_state_nxt  = ST_RUN;
          w_cnt_nxt    = '0;
          w_active_nxt = r_pending;
        end else begin
          w_cnt_nxt = r_cnt + RATIO_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_active  <= RATIO_W'(RATIO_DEFAULT);
      r_pending <= RATIO_W'(RATIO_DEFAULT);
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      r_err     <= w_accept & w_dec_err;
    end
  end

  assign div_tick     = w_running & w_wrap;
  assign div_clk      = w_running & (r_cnt < w_half);
  assign active_ratio = r_active;
  assign busy         = (r_state == ST_PEND);
  assign cfg_err      = r_err;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: expected tick cycles are queued when stimulus is driven.
module tb_div_ratio_ctrl;

  localparam int unsigned PW = 6;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_valid;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_ready;
  logic          cfg_err;
  logic          div_tick;
  logic          div_clk;
  logic [RW-1:0] active_ratio;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  div_ratio_ctrl #(
    .PRESCALE_W (PW),
    .RATIO_W    (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_prescale (cfg_prescale),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .div_tick     (div_tick),
    .div_clk      (div_clk),
    .active_ratio (active_ratio),
    .busy         (busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_prescale = '0;
    next_cycle();
    next_cycle();
    checks++;
    if (active_ratio !== 8'd1) begin
      errors++; $display("FAIL reset_ratio: got %0d expected 1", active_ratio);
    end
    checks++;
    if ({div_tick, div_clk, cfg_err, busy, cfg_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_flags: got %b expected 00001", {div_tick, div_clk, cfg_err, busy, cfg_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e;
    logic exp_clk;
    cfg_valid = 1'b1; cfg_prescale = 6'd8;
    next_cycle();
    cfg_valid = 1'b0;
    checks++;
    if (active_ratio !== 8'd4) begin
      errors++; $display("FAIL basic_ratio: got %0d expected 4", active_ratio);
    end
    checks++;
    if ({div_tick, div_clk, cfg_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL basic_off_flags: got %b expected 0000", {div_tick, div_clk, cfg_err, busy});
    end
    en = 1'b1;
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
    next_cycle();
    for (int c = 1; c <= 12; c++) begin
      exp_clk = (((c - 1) % 4) < 2);
      checks++;
      if (div_clk !== exp_clk) begin
        errors++; $display("FAIL basic_div_clk: cycle %0d got %b expected %b", c, div_clk, exp_clk);
      end
      if (div_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_tick: unexpected tick at cycle %0d expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            errors++; $display("FAIL basic_tick: got cycle %0d expected cycle %0d", c, e);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL basic_missing_tick: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pend_switch();
    int e;
    next_cycle();
    cfg_valid = 1'b1; cfg_prescale = 6'd4;
    next_cycle();
    cfg_valid = 1'b0;
    checks++;
    if ({busy, cfg_ready, active_ratio} !== {2'b10, 8'd4}) begin
      errors++; $display("FAIL pend_enter: got busy/ready %b ratio %0d expected 10 ratio 4", {busy, cfg_ready}, active_ratio);
    end
    next_cycle();
    checks++;
    if ({div_tick, busy, cfg_ready} !== 3'b110) begin
      errors++; $display("FAIL pend_old_tick: got %b expected 110", {div_tick, busy, cfg_ready});
    end
    exp_q.push_back(8);
    next_cycle();
    for (int t = 1; t <= 10; t++) begin
      if (t == 1) begin
        checks++;
        if ({busy, cfg_ready, active_ratio} !== {2'b01, 8'd8}) begin
          errors++; $display("FAIL pend_commit: got busy/ready %b ratio %0d expected 01 ratio 8", {busy, cfg_ready}, active_ratio);
        end
      end
      if (div_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL pend_tick: unexpected tick at %0d expected none", t);
        end else begin
          e = exp_q.pop_front();
          if (t !== e) begin
            errors++; $display("FAIL pend_tick: got %0d expected %0d", t, e);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL pend_missing_tick: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_err();
    int n;
    cfg_valid = 1'b1; cfg_prescale = 6'd20;
    next_cycle();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_err, busy} !== 2'b11) begin
      errors++; $display("FAIL err_pulse: got %b expected 11", {cfg_err, busy});
    end
    next_cycle();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL err_width: got %b expected 0", cfg_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      next_cycle();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL err_commit_timeout: got busy %b expected 0", busy);
    end
    checks++;
    if (active_ratio !== 8'd1) begin
      errors++; $display("FAIL err_ratio: got %0d expected 1", active_ratio);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({div_tick, div_clk} !== 2'b11) begin
        errors++; $display("FAIL err_ratio1_out: cycle %0d got %b expected 11", i, {div_tick, div_clk});
      end
      next_cycle();
    end
  endtask

  task automatic test_cfg_with_en();
    int e;
    en = 1'b0;
    next_cycle();
    checks++;
    if ({div_tick, div_clk, busy, cfg_ready} !== 4'b0001) begin
      errors++; $display("FAIL off_flags: got %b expected 0001", {div_tick, div_clk, busy, cfg_ready});
    end
    cfg_valid = 1'b1; cfg_prescale = 6'd4; en = 1'b1;
    exp_q.push_back(8);
    next_cycle();
    cfg_valid = 1'b0;
    checks++;
    if (active_ratio !== 8'd8) begin
      errors++; $display("FAIL cfg_en_ratio: got %0d expected 8", active_ratio);
    end
    for (int c = 1; c <= 9; c++) begin
      if (div_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL cfg_en_tick: unexpected tick at %0d expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            errors++; $display("FAIL cfg_en_tick: got %0d expected %0d", c, e);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL cfg_en_missing_tick: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pend_en_drop();
    cfg_valid = 1'b1; cfg_prescale = 6'd16;
    next_cycle();
    cfg_valid = 1'b0;
    checks++;
    if ({busy, active_ratio} !== {1'b1, 8'd8}) begin
      errors++; $display("FAIL drop_pend: got busy %b ratio %0d expected busy 1 ratio 8", busy, active_ratio);
    end
    en = 1'b0;
    next_cycle();
    checks++;
    if (active_ratio !== 8'd2) begin
      errors++; $display("FAIL drop_commit: got %0d expected 2", active_ratio);
    end
    checks++;
    if ({div_tick, div_clk, busy, cfg_ready} !== 4'b0001) begin
      errors++; $display("FAIL drop_flags: got %b expected 0001", {div_tick, div_clk, busy, cfg_ready});
    end
  endtask

  task automatic test_hold_valid();
    int acc;
    en = 1'b1;
    next_cycle();
    cfg_valid = 1'b1; cfg_prescale = 6'd8;
    next_cycle();
    checks++;
    if ({busy, cfg_ready} !== 2'b10) begin
      errors++; $display("FAIL hold_pend: got %b expected 10", {busy, cfg_ready});
    end
    cfg_prescale = 6'd32;
    next_cycle();
    checks++;
    if ({busy, cfg_ready, active_ratio} !== {2'b01, 8'd4}) begin
      errors++; $display("FAIL hold_ignored: got busy/ready %b ratio %0d expected 01 ratio 4", {busy, cfg_ready}, active_ratio);
    end
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
        acc++;
        next_cycle();
        cfg_valid = 1'b0;
      end else begin
        next_cycle();
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (acc !== 1) begin
      errors++; $display("FAIL hold_accept_count: got %0d expected 1", acc);
    end
    checks++;
    if ({busy, active_ratio} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL hold_commit: got busy %b ratio %0d expected busy 0 ratio 1", busy, active_ratio);
    end
  endtask

  task automatic test_rst_pend();
    cfg_valid = 1'b1; cfg_prescale = 6'd4;
    next_cycle();
    cfg_valid = 1'b0;
    next_cycle();
    checks++;
    if (active_ratio !== 8'd8) begin
      errors++; $display("FAIL rst_setup_ratio: got %0d expected 8", active_ratio);
    end
    next_cycle();
    cfg_valid = 1'b1; cfg_prescale = 6'd16;
    next_cycle();
    cfg_valid = 1'b0;
    next_cycle();
    checks++;
    if ({busy, div_clk, div_tick} !== 3'b110) begin
      errors++; $display("FAIL rst_setup_cnt3: got %b expected 110", {busy, div_clk, div_tick});
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    checks++;
    if (active_ratio !== 8'd1) begin
      errors++; $display("FAIL rst_mid_ratio: got %0d expected 1", active_ratio);
    end
    checks++;
    if ({div_tick, div_clk, cfg_err, busy, cfg_ready} !== 5'b00001) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 00001", {div_tick, div_clk, cfg_err, busy, cfg_ready});
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({div_tick, div_clk, busy, active_ratio} !== {3'b110, 8'd1}) begin
        errors++; $display("FAIL rst_discard: cycle %0d got flags %b ratio %0d expected 110 ratio 1", i, {div_tick, div_clk, busy}, active_ratio);
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_pend_switch();
    test_err();
    test_cfg_with_en();
    test_pend_en_drop();
    test_hold_valid();
    test_rst_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
